// File: rtl/square_field_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : square_field_pkg
//  Purpose  : Shared constants, zone defaults and slot/column index helpers
//             for the falling-square playfield.
//  Revision : 1.0  initial release
// ============================================================================
package square_field_pkg;

  localparam int NUM_COLS      = 4;
  localparam int SLOTS_PER_COL = 6;
  localparam int NUM_SLOTS     = NUM_COLS * SLOTS_PER_COL;
  localparam int Y_W           = 10;
  localparam int SUM_W         = Y_W + 1;
  localparam int SPEED_W       = 8;

  // Default geometry: 640x480 screen, scrolled at 60 Hz from a 100 MHz clock.
  localparam int DEF_TICK_DIV  = 1666667;
  localparam int DEF_SCREEN_H  = 480;
  localparam int DEF_HIT_TOP   = 400;
  localparam int DEF_HIT_BOT   = 439;
  localparam int DEF_END_TOP   = 440;

  // Column that owns slot k.
  function automatic int slot_col(input int k);
    return k / SLOTS_PER_COL;
  endfunction

  // Position of slot k inside its column group.
  function automatic int slot_idx(input int k);
    return k % SLOTS_PER_COL;
  endfunction

  // Flat slot index of entry i in column c.
  function automatic int col_slot(input int c, input int i);
    return c * SLOTS_PER_COL + i;
  endfunction

endpackage
`default_nettype wire

// File: rtl/square_slot.sv
`default_nettype none
// ============================================================================
//  Module   : square_slot
//  Purpose  : One playfield square: occupancy flag, vertical position,
//             scroll step with screen-exit, and hit/end zone decode.
//  Revision : 1.0  initial release
// ============================================================================
module square_slot
  import square_field_pkg::*;
#(
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int HIT_TOP  = DEF_HIT_TOP,
  parameter int HIT_BOT  = DEF_HIT_BOT,
  parameter int END_TOP  = DEF_END_TOP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spawn,
  input  logic               remove,
  input  logic               tick,
  input  logic [SPEED_W-1:0] speed,
  output logic               act,
  output logic [Y_W-1:0]     y,
  output logic               hit_zone,
  output logic               end_zone
);

  localparam logic [SUM_W-1:0] c_screen_h = SUM_W'(SCREEN_H);
  localparam logic [Y_W-1:0]   c_hit_top  = Y_W'(HIT_TOP);
  localparam logic [Y_W-1:0]   c_hit_bot  = Y_W'(HIT_BOT);
  localparam logic [Y_W-1:0]   c_end_top  = Y_W'(END_TOP);

  logic             r_act;
  logic [Y_W-1:0]   r_y;
  logic [SUM_W-1:0] w_sum;

  // One extra bit so a step past the bottom edge cannot wrap back on screen.
  assign w_sum = {1'b0, r_y} + {{(SUM_W-SPEED_W){1'b0}}, speed};

  // Slot state: remove beats move; spawn only lands on a free slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_act <= 1'b0;
      r_y   <= '0;
    end else if (remove && r_act) begin
      r_act <= 1'b0;
      r_y   <= '0;
    end else if (spawn && !r_act) begin
      r_act <= 1'b1;
      r_y   <= '0;
    end else if (tick && r_act) begin
      if (w_sum >= c_screen_h) begin
        r_act <= 1'b0;
        r_y   <= '0;
      end else begin
        r_y   <= w_sum[Y_W-1:0];
      end
    end
  end

  assign act      = r_act;
  assign y        = r_y;
  assign hit_zone = r_act && (r_y >= c_hit_top) && (r_y <= c_hit_bot);
  assign end_zone = r_act && (r_y >= c_end_top);

endmodule
`default_nettype wire

// File: rtl/square_field.sv
`default_nettype none
// ============================================================================
//  Module   : square_field
//  Purpose  : 24-slot playfield (4 columns x 6 slots). Allocates spawns,
//             scrolls squares on a divided frame tick, honours hit removals
//             and reports per-slot zone flags and positions.
//  Revision : 1.0  initial release
// ============================================================================
module square_field
  import square_field_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int HIT_TOP  = DEF_HIT_TOP,
  parameter int HIT_BOT  = DEF_HIT_BOT,
  parameter int END_TOP  = DEF_END_TOP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic [NUM_COLS-1:0]      column,
  input  logic [NUM_SLOTS-1:0]     remove,
  input  logic [SPEED_W-1:0]       speed,
  output logic [2*NUM_SLOTS-1:0]   square_locations,
  output logic [NUM_SLOTS-1:0]     active,
  output logic [NUM_SLOTS*Y_W-1:0] pos_y,
  output logic                     overflow
);

  localparam int                 c_cnt_w    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TICK_DIV - 1);

  logic [c_cnt_w-1:0]                        r_tick_cnt;
  logic                                      w_tick;
  logic [NUM_COLS-1:0][SLOTS_PER_COL-1:0]    w_grant;
  logic [NUM_COLS-1:0]                       w_drop;
  logic                                      r_overflow;

  assign w_tick = run && (r_tick_cnt == c_cnt_last);

  // Scroll divider; keeps its phase while the game is paused.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (run) begin
      if (w_tick) begin
        r_tick_cnt <= '0;
      end else begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end
    end
  end

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    logic                     w_req;
    logic                     w_free;
    logic [SLOTS_PER_COL-1:0] w_grp_grant;

    assign w_req = run && column[c];

    // Grant the request to the lowest-index slot of this column that is free
    // before the edge; a slot cleared this cycle is only reusable next cycle.
    always_comb begin
      w_grp_grant = '0;
      w_free      = 1'b0;
      for (int i = 0; i < SLOTS_PER_COL; i++) begin
        if (!w_free && !active[col_slot(c, i)]) begin
          w_grp_grant[i] = w_req;
          w_free         = 1'b1;
        end
      end
    end

    assign w_grant[c] = w_grp_grant;
    assign w_drop[c]  = w_req && !w_free;
  end

  // Any dropped spawn this cycle yields a single-cycle overflow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= |w_drop;
    end
  end

  assign overflow = r_overflow;

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    square_slot #(
      .SCREEN_H (SCREEN_H),
      .HIT_TOP  (HIT_TOP),
      .HIT_BOT  (HIT_BOT),
      .END_TOP  (END_TOP)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .spawn    (w_grant[slot_col(k)][slot_idx(k)]),
      .remove   (remove[k]),
      .tick     (w_tick),
      .speed    (speed),
      .act      (active[k]),
      .y        (pos_y[k*Y_W +: Y_W]),
      .hit_zone (square_locations[2*k]),
      .end_zone (square_locations[2*k+1])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_square_field.sv
`default_nettype none
// ============================================================================
//  Module   : tb_square_field
//  Purpose  : Directed self-checking bench for square_field (TICK_DIV = 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_square_field;
  import square_field_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         run;
  logic [3:0]   column;
  logic [23:0]  remove;
  logic [7:0]   speed;
  logic [47:0]  square_locations;
  logic [23:0]  active;
  logic [239:0] pos_y;
  logic         overflow;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic        run;
    logic [3:0]  column;
    logic [23:0] remove;
    logic [23:0] exp_act;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];

  square_field #(
    .TICK_DIV (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .run              (run),
    .column           (column),
    .remove           (remove),
    .speed            (speed),
    .square_locations (square_locations),
    .active           (active),
    .pos_y            (pos_y),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [9:0] y_of(input int k);
    return pos_y[k*10 +: 10];
  endfunction

  task automatic add(input logic r, input logic rn, input logic [3:0] col,
                     input logic [23:0] rem, input logic [23:0] ea, input logic eo);
    vec_t v;
    v.rst = r; v.run = rn; v.column = col; v.remove = rem;
    v.exp_act = ea; v.exp_ovf = eo;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b1; column = 4'h0; remove = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; column = 4'h0; remove = '0; speed = 8'd0;

    // Allocation / overflow / removal vectors, speed 0 so ticks move nothing.
    add(1, 1, 4'hF, 24'h0,      24'h000000, 0);
    add(0, 1, 4'h1, 24'h0,      24'h000001, 0);
    add(0, 1, 4'h2, 24'h0,      24'h000041, 0);
    add(0, 1, 4'h2, 24'h0,      24'h0000C1, 0);
    add(0, 1, 4'h2, 24'h0,      24'h0001C1, 0);
    add(0, 1, 4'h2, 24'h0,      24'h0003C1, 0);
    add(0, 1, 4'h2, 24'h0,      24'h0007C1, 0);
    add(0, 1, 4'h2, 24'h0,      24'h000FC1, 0);
    add(0, 1, 4'h2, 24'h0,      24'h000FC1, 1);
    add(0, 1, 4'h0, 24'h0,      24'h000FC1, 0);
    add(0, 1, 4'hC, 24'h0,      24'h041FC1, 0);
    add(0, 1, 4'h4, 24'h0,      24'h043FC1, 0);
    add(0, 1, 4'h4, 24'h0,      24'h047FC1, 0);
    add(0, 1, 4'h4, 24'h0,      24'h04FFC1, 0);
    add(0, 1, 4'h4, 24'h0,      24'h05FFC1, 0);
    add(0, 1, 4'h4, 24'h0,      24'h07FFC1, 0);
    add(0, 1, 4'h4, 24'h001000, 24'h07EFC1, 1);
    add(0, 1, 4'h4, 24'h0,      24'h07FFC1, 0);
    add(0, 1, 4'h0, 24'h000002, 24'h07FFC1, 0);
    add(0, 1, 4'h0, 24'h000FC0, 24'h07F001, 0);
    add(0, 0, 4'h1, 24'h0,      24'h07F001, 0);
    add(0, 0, 4'h2, 24'h000001, 24'h07F000, 0);
    add(0, 1, 4'hF, 24'h0,      24'h0FF041, 1);
    add(0, 1, 4'h0, 24'h0,      24'h0FF041, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; run = vecs[i].run;
      column = vecs[i].column; remove = vecs[i].remove;
      step();
      chk($sformatf("vec%0d active", i), 64'(active), 64'(vecs[i].exp_act));
      chk($sformatf("vec%0d overflow", i), 64'(overflow), 64'(vecs[i].exp_ovf));
      chk($sformatf("vec%0d locations", i), 64'(square_locations), 64'h0);
      chk($sformatf("vec%0d pos_y_zero", i), 64'(pos_y == '0), 64'h1);
    end
    column = 4'h0; remove = '0;

    // Scroll of one column-2 square through hit zone, end zone and exit.
    do_reset();
    speed = 8'd40; column = 4'h4;
    step();
    column = 4'h0;
    chk("scroll spawn", 64'(active), 64'h001000);
    for (int cyc = 2; cyc <= 48; cyc++) begin
      step();
      case (cyc)
        3:  chk("scroll y c3", 64'(y_of(12)), 64'd0);
        4:  chk("scroll y c4", 64'(y_of(12)), 64'd40);
        39: begin
          chk("scroll y c39", 64'(y_of(12)), 64'd360);
          chk("scroll loc c39", 64'(square_locations), 64'h0);
        end
        40: begin
          chk("scroll y c40", 64'(y_of(12)), 64'd400);
          chk("scroll loc c40", 64'(square_locations), 64'h1 << 24);
        end
        43: chk("scroll y c43", 64'(y_of(12)), 64'd400);
        44: begin
          chk("scroll y c44", 64'(y_of(12)), 64'd440);
          chk("scroll loc c44", 64'(square_locations), 64'h1 << 25);
        end
        47: chk("scroll loc c47", 64'(square_locations), 64'h1 << 25);
        48: begin
          chk("scroll exit act", 64'(active), 64'h0);
          chk("scroll exit loc", 64'(square_locations), 64'h0);
          chk("scroll exit y", 64'(y_of(12)), 64'd0);
        end
        default: ;
      endcase
    end

    // Hit-zone removal held for five cycles, then slot reuse.
    do_reset();
    column = 4'h1;
    step();
    column = 4'h0;
    for (int cyc = 2; cyc <= 40; cyc++) step();
    chk("rm pre y", 64'(y_of(0)), 64'd400);
    chk("rm pre loc", 64'(square_locations), 64'h1);
    remove = 24'h000001;
    for (int cyc = 41; cyc <= 45; cyc++) begin
      step();
      chk($sformatf("rm c%0d act", cyc), 64'(active), 64'h0);
      chk($sformatf("rm c%0d loc", cyc), 64'(square_locations), 64'h0);
    end
    remove = '0; column = 4'h1;
    step();
    column = 4'h0;
    chk("reuse act", 64'(active), 64'h1);
    chk("reuse y", 64'(y_of(0)), 64'd0);
    step();
    column = 4'h2;
    step();
    column = 4'h0;
    chk("tick spawn act", 64'(active), 64'h41);
    chk("tick spawn y0", 64'(y_of(0)), 64'd40);
    chk("tick spawn y6", 64'(y_of(6)), 64'd0);
    for (int cyc = 49; cyc <= 52; cyc++) step();
    chk("next tick y0", 64'(y_of(0)), 64'd80);
    chk("next tick y6", 64'(y_of(6)), 64'd40);

    // Pause two cycles into a tick period, then resume at the held phase.
    step();
    step();
    run = 1'b0; column = 4'h1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("freeze%0d y0", i), 64'(y_of(0)), 64'd80);
      chk($sformatf("freeze%0d act", i), 64'(active), 64'h41);
    end
    run = 1'b1; column = 4'h0;
    step();
    chk("resume1 y0", 64'(y_of(0)), 64'd80);
    step();
    chk("resume2 y0", 64'(y_of(0)), 64'd120);
    chk("resume2 y6", 64'(y_of(6)), 64'd80);

    // Reset mid-play overrides every other input and clears the tick phase.
    rst = 1'b1; column = 4'hF; remove = 24'hFFFFFF;
    step();
    chk("midrst act", 64'(active), 64'h0);
    chk("midrst loc", 64'(square_locations), 64'h0);
    chk("midrst pos", 64'(pos_y == '0), 64'h1);
    chk("midrst ovf", 64'(overflow), 64'h0);
    rst = 1'b0; remove = '0; column = 4'h1;
    step();
    column = 4'h0;
    step();
    step();
    chk("post rst c3", 64'(y_of(0)), 64'd0);
    step();
    chk("post rst c4", 64'(y_of(0)), 64'd40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
